// File: rtl/mac_unpack_div.sv
// mac_unpack_div: undoes a multiply-accumulate result Y = A*B + C.
// Computes Q = (Y - C) / B and R = (Y - C) % B with a bit-serial restoring
// divider behind a start/done handshake. Division by zero and Y < C are
// reported as errors instead of producing a result.
module mac_unpack_div #(
    parameter int katusha = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [2*katusha-1:0]   Y_in,
    input  logic [katusha-1:0]     B_in,
    input  logic [katusha-1:0]     C_in,
    output logic                   busy,
    output logic                   done,
    output logic [2*katusha-1:0]   Q_out,
    output logic [katusha-1:0]     R_out,
    output logic                   exact,
    output logic                   err_div0,
    output logic                   err_under
);

    localparam int W2 = 2 * katusha;
    localparam int CW = $clog2(W2);
    localparam logic [CW-1:0] LastCnt = CW'(W2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        ITER,
        DONE
    } state_t;

    state_t              state_q;
    logic [W2-1:0]       y_q;
    logic [katusha-1:0]  b_q;
    logic [katusha-1:0]  c_q;
    logic [katusha:0]    rem_q;
    logic [W2-1:0]       dividend_q;
    logic [CW-1:0]       cnt_q;

    logic                busy_q;
    logic                done_q;
    logic [W2-1:0]       q_out_q;
    logic [katusha-1:0]  r_out_q;
    logic                exact_q;
    logic                err_div0_q;
    logic                err_under_q;

    logic [W2-1:0]       cExt;
    logic [W2-1:0]       diff_d;
    logic                under_d;
    logic [katusha+1:0]  trial;
    logic [katusha+1:0]  bExt;
    logic                qBit_d;
    logic [katusha:0]    rem_d;
    logic [W2-1:0]       dividend_d;

    // Offset subtraction for PREP and one restoring-division step for ITER.
    // The trial value is one bit wider than the remainder register so the
    // shift never loses the top bit; the kept remainder is always below B.
    always_comb begin
        cExt       = {{katusha{1'b0}}, c_q};
        diff_d     = y_q - cExt;
        under_d    = (y_q < cExt);
        trial      = {rem_q, dividend_q[W2-1]};
        bExt       = {2'b00, b_q};
        qBit_d     = (trial >= bExt);
        rem_d      = qBit_d ? (katusha+1)'(trial - bExt) : trial[katusha:0];
        dividend_d = {dividend_q[W2-2:0], qBit_d};
    end

    // Control FSM with registered handshake, result and flag outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            y_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            rem_q       <= '0;
            dividend_q  <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            q_out_q     <= '0;
            r_out_q     <= '0;
            exact_q     <= 1'b0;
            err_div0_q  <= 1'b0;
            err_under_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        y_q         <= Y_in;
                        b_q         <= B_in;
                        c_q         <= C_in;
                        exact_q     <= 1'b0;
                        err_div0_q  <= 1'b0;
                        err_under_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= PREP;
                    end
                end
                PREP: begin
                    if (b_q == '0) begin
                        err_div0_q <= 1'b1;
                        q_out_q    <= '0;
                        r_out_q    <= '0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end else if (under_d) begin
                        err_under_q <= 1'b1;
                        q_out_q     <= '0;
                        r_out_q     <= '0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        rem_q      <= '0;
                        dividend_q <= diff_d;
                        cnt_q      <= '0;
                        state_q    <= ITER;
                    end
                end
                ITER: begin
                    rem_q      <= rem_d;
                    dividend_q <= dividend_d;
                    cnt_q      <= cnt_q + CW'(1);
                    if (cnt_q == LastCnt) begin
                        q_out_q <= dividend_d;
                        r_out_q <= rem_d[katusha-1:0];
                        exact_q <= (rem_d == '0);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign Q_out     = q_out_q;
    assign R_out     = r_out_q;
    assign exact     = exact_q;
    assign err_div0  = err_div0_q;
    assign err_under = err_under_q;

endmodule
